backoff_ctl: RTL and testbench
==============================

BACKOFF_CTL -- requirements
Module: backoff_ctl

Interface
REQ-001 SHALL have parameter CNT_W, default 12, meaning the width of the IFS and slot cycle counters.
REQ-002 SHALL have parameter SLOT_CNT_W, default 10, meaning the width of the backoff slot count (max CW 1023).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value; a value of 0 SHALL be replaced by 1.
REQ-004 SHALL have clk  in  1  sole clock; all logic is in this domain.
REQ-005 SHALL have rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ch_idle  in  1  channel idle indication from the CCA block, level.
REQ-007 SHALL have tx_req  in  1  pulse; a frame is pending transmission.
REQ-008 SHALL have tx_done  in  1  pulse; the granted transmission has finished.
REQ-009 SHALL have abort  in  1  pulse; drop the current attempt.
REQ-010 SHALL have ifs_time  in  CNT_W  IFS (DIFS/AIFS) length in clk cycles.
REQ-011 SHALL have slot_time  in  CNT_W  slot length in clk cycles.
REQ-012 SHALL have cw_exp  in  4  contention window exponent; CW = 2^cw_exp - 1.
REQ-013 SHALL have tx_grant  out  1  one-cycle pulse; the transmission may start.
REQ-014 SHALL have busy  out  1  high in every state except IDLE.
REQ-015 SHALL have slots_left  out  SLOT_CNT_W  remaining backoff slots.
REQ-016 SHALL have state  out  3  current FSM state encoding, for debug.

Function
REQ-017 SHALL implement states IDLE=0, IFS=1, BACKOFF=2, GRANT=3, WAIT_DONE=4; all other encodings SHALL return to IDLE.
REQ-018 SHALL run a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances every cycle, independent of state.
REQ-019 SHALL, in IDLE on tx_req, load slots_left = lfsr[9:0] & CW, clear the cycle counter and enter IFS on the next cycle.
REQ-020 SHALL clamp cw_exp values above 10 to 10 at draw time.
REQ-021 SHALL, in IFS, increment the cycle counter on each cycle with ch_idle=1, and reset the counter to 0 on each cycle with ch_idle=0.
REQ-022 SHALL leave IFS when the counter reaches ifs_time (ifs_time=0 means a single idle cycle): to GRANT if slots_left=0, otherwise to BACKOFF with the counter cleared.
REQ-023 SHALL, in BACKOFF, count idle cycles up to max(slot_time,1), then decrement slots_left and clear the counter; slots_left reaching 0 SHALL enter GRANT.
REQ-024 SHALL, in BACKOFF on ch_idle=0, freeze slots_left (the partial slot does not count), clear the counter and return to IFS.
REQ-025 SHALL assert tx_grant for exactly the one cycle spent in GRANT, then enter WAIT_DONE.
REQ-026 SHALL, in WAIT_DONE, return to IDLE on tx_done.
REQ-027 SHALL, on abort in any non-IDLE state, return to IDLE, clear slots_left and suppress tx_grant that cycle; abort SHALL take priority over tx_done and over a counter expiry in the same cycle.
REQ-028 SHALL ignore tx_req outside IDLE; there is no queuing.
REQ-029 SHALL use saturating counters, with no wrap-around past 2^CNT_W-1.
REQ-030 SHALL latch ifs_time, slot_time and cw_exp when compared; changes mid-operation take effect on the next comparison.

Reset
REQ-031 SHALL, while rstn=0, force state=IDLE, counters=0, slots_left=0, tx_grant=0, busy=0 and lfsr=LFSR_SEED; a mid-operation reset discards the attempt, with no grant after release.
REQ-032 SHALL drive all outputs from registers only, with no combinational input-to-output paths.

Structure
REQ-033 SHALL place the state encodings, the LFSR taps and the CW exponent clamp (10) in a shared package (backoff_pkg) used by RTL and bench.
REQ-034 SHALL use one sub-module, backoff_lfsr (free-running 16-bit LFSR with a seed parameter); all other logic lives in backoff_ctl.

Verification
REQ-035 SHALL cover: ch_idle=1 constant, ifs_time=34, slot_time=9, cw_exp=0, tx_req -> tx_grant exactly 36 cycles after tx_req (1 load + 34 IFS + 1 GRANT).
REQ-036 SHALL cover: forced draw slots_left=3, slot_time=9, ch idle -> tx_grant after IFS + 27 idle cycles; slots_left steps 3,2,1,0.
REQ-037 SHALL cover: ch_idle=0 for 5 cycles mid-slot 2 of 3 -> slots_left holds 2, IFS restarts from 0, grant delayed by 5+34+partial slot.
REQ-038 SHALL cover: abort and tx_done asserted together in WAIT_DONE, and abort during BACKOFF -> IDLE, slots_left=0, no tx_grant.
REQ-039 SHALL cover: rstn asserted in BACKOFF, then released -> all outputs 0, state=0, next tx_req starts a fresh draw.
REQ-040 SHALL cover: cw_exp=15 over 1000 draws -> slots_left is never above 1023.

Source files
------------

// File: rtl/backoff_pkg.sv
// Shared definitions for the backoff controller: FSM encodings, LFSR taps,
// contention-window clamp and the draw mask helper.
package backoff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IFS       = 3'd1,
    ST_BACKOFF   = 3'd2,
    ST_GRANT     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback is the
  // XOR of bits 0, 2, 3 and 5, shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int unsigned DRAW_W     = 10;
  localparam logic [3:0]  CW_EXP_MAX = 4'd10;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

  // CW = 2^e - 1 with e clamped, expressed as a DRAW_W-bit mask.
  function automatic logic [DRAW_W-1:0] cw_mask(input logic [3:0] e);
    logic [3:0]        ec;
    logic [DRAW_W-1:0] m;
    ec = (e > CW_EXP_MAX) ? CW_EXP_MAX : e;
    m  = '0;
    for (int i = 0; i < DRAW_W; i++) begin
      m[i] = (i < int'(ec));
    end
    return m;
  endfunction

endpackage

// File: rtl/backoff_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle out of reset and
// exposes its low OUT_W bits as the random draw source.
module backoff_lfsr
  import backoff_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = DRAW_W
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [OUT_W-1:0] value
);

  // An all-zero state would lock the register up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/backoff_ctl.sv
// Channel-access backoff controller: waits an idle IFS, counts down a random
// number of idle slots (freezing on a busy channel), then pulses tx_grant.
module backoff_ctl
  import backoff_pkg::*;
#(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SLOT_CNT_W = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ch_idle,
  input  logic                  tx_req,
  input  logic                  tx_done,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      ifs_time,
  input  logic [CNT_W-1:0]      slot_time,
  input  logic [3:0]            cw_exp,
  output logic                  tx_grant,
  output logic                  busy,
  output logic [SLOT_CNT_W-1:0] slots_left,
  output logic [2:0]            state
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SLOT_CNT_W-1:0] slots_q, slots_d;
  logic                  grant_q, grant_d;
  logic                  busy_q, busy_d;

  logic [DRAW_W-1:0]     rnd;
  logic [DRAW_W-1:0]     draw;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      ifs_lim;
  logic [CNT_W-1:0]      slot_lim;

  backoff_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (DRAW_W)
  ) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .value (rnd)
  );

  // Timing inputs are sampled at the cycle they are compared, so a change
  // mid-attempt applies from the next comparison onward.
  assign draw     = rnd & cw_mask(cw_exp);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign ifs_lim  = (ifs_time  == '0) ? CNT_W'(1) : ifs_time;
  assign slot_lim = (slot_time == '0) ? CNT_W'(1) : slot_time;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slots_d = slots_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_req) begin
          slots_d = SLOT_CNT_W'(draw);
          cnt_d   = '0;
          state_d = ST_IFS;
        end
      end

      ST_IFS: begin
        if (!ch_idle) begin
          cnt_d = '0;
        end else if (cnt_inc >= ifs_lim) begin
          cnt_d   = '0;
          state_d = (slots_q == '0) ? ST_GRANT : ST_BACKOFF;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_BACKOFF: begin
        if (!ch_idle) begin
          // A partially elapsed slot is forfeited; slots_left is frozen.
          cnt_d   = '0;
          state_d = ST_IFS;
        end else if (cnt_inc >= slot_lim) begin
          cnt_d   = '0;
          slots_d = slots_q - SLOT_CNT_W'(1);
          if (slots_q == SLOT_CNT_W'(1)) begin
            state_d = ST_GRANT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_GRANT: begin
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        slots_d = '0;
      end
    endcase

    // Abort wins over tx_done and over any counter expiry in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      slots_d = '0;
    end
  end

  // Outputs are registered copies of the next state, aligned with state_q.
  assign grant_d = (state_d == ST_GRANT);
  assign busy_d  = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slots_q <= '0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_grant   = grant_q;
  assign busy       = busy_q;
  assign slots_left = slots_q;
  assign state      = state_q;

endmodule

// File: tb/tb_backoff_ctl.sv
// Self-checking bench for backoff_ctl: expected grant cycles are queued when
// tx_req is driven and popped when the DUT pulses tx_grant.
module tb_backoff_ctl;
  import backoff_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ch_idle = 1'b1;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] ifs_time = 12'd34;
  logic [11:0] slot_time = 12'd9;
  logic [3:0]  cw_exp = 4'd0;
  logic        tx_grant;
  logic        busy;
  logic [9:0]  slots_left;
  logic [2:0]  state;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned exp_q[$];
  int unsigned last_grant_cyc = 0;
  int unsigned popped;
  logic [15:0] m_lfsr;

  backoff_ctl #(
    .CNT_W      (12),
    .SLOT_CNT_W (10),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ch_idle    (ch_idle),
    .tx_req     (tx_req),
    .tx_done    (tx_done),
    .abort      (abort),
    .ifs_time   (ifs_time),
    .slot_time  (slot_time),
    .cw_exp     (cw_exp),
    .tx_grant   (tx_grant),
    .busy       (busy),
    .slots_left (slots_left),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR, written out bit by bit from the polynomial.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && tx_grant) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        last_grant_cyc = cyc;
        check("grant_cycle", cyc, popped);
        check("grant_slots", slots_left, 0);
        check("grant_state", state, ST_GRANT);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int unsigned lim(input logic [11:0] v);
    return (v == 12'd0) ? 1 : int'(v);
  endfunction

  // Issue tx_req; optionally queue the grant cycle expected on an idle channel
  // plus `extra` cycles of planned disturbance.
  task automatic send_req(input bit want_grant, input int unsigned extra,
                          output logic [9:0] draw, output int unsigned c0);
    int unsigned e;
    int unsigned m;
    e    = (cw_exp > CW_EXP_MAX) ? int'(CW_EXP_MAX) : int'(cw_exp);
    m    = (1 << e) - 1;
    draw = m_lfsr[9:0] & m[9:0];
    c0   = cyc;
    if (want_grant)
      exp_q.push_back(c0 + 1 + lim(ifs_time) + int'(draw) * lim(slot_time) + extra);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("draw", slots_left, draw);
    check("load_state", state, ST_IFS);
  endtask

  task automatic wait_grant(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    if (exp_q.size() != 0) begin
      check("grant_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic finish_tx();
    tick();
    check("post_grant_pulse", tx_grant, 0);
    check("wait_done_state", state, ST_WAIT_DONE);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_state", state, ST_IDLE);
    check("done_busy", busy, 0);
  endtask

  // Wait until the next draw with cw_exp=2 will yield 3.
  task automatic wait_draw3();
    for (int i = 0; i < 200; i++) begin
      if (m_lfsr[1:0] == 2'b11) return;
      tick();
    end
    check("draw3_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_state(input state_t s, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (state == s) return;
      tick();
    end
    check(tag, state, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  d;
    int unsigned c0;
    int unsigned prev;
    int          n;
    int          draw_err;
    int unsigned max_draw;

    repeat (3) tick();
    check("rst_state", state, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_grant", tx_grant, 0);
    check("rst_slots", slots_left, 0);
    rstn = 1'b1;
    tick();

    // Zero-slot attempt: grant in cycle 36 counting the tx_req cycle as 1.
    cw_exp = 4'd0; ifs_time = 12'd34; slot_time = 12'd9;
    send_req(1'b1, 0, d, c0);
    check("busy_in_ifs", busy, 1);
    wait_grant(100);
    check("req035_latency", last_grant_cyc - c0 + 1, 36);
    tick();
    check("one_cycle_grant", tx_grant, 0);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("req_ignored_state", state, ST_WAIT_DONE);
    check("req_ignored_slots", slots_left, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_state", state, ST_IDLE);

    // Three slots on an idle channel: steps 3,2,1,0 on slot boundaries.
    cw_exp = 4'd2;
    wait_draw3();
    send_req(1'b1, 0, d, c0);
    check("forced_draw", d, 3);
    prev = slots_left;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (slots_left != prev) begin
        n++;
        check("slot_step_val", slots_left, 3 - n);
        check("slot_step_cyc", cyc, c0 + 1 + 34 + n * 9);
        prev = slots_left;
      end
      if (exp_q.size() == 0) break;
    end
    check("slot_steps", n, 3);
    if (exp_q.size() != 0) begin
      check("grant_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    finish_tx();

    // Busy channel for 5 cycles after 4 idle cycles of slot 2.
    wait_draw3();
    send_req(1'b1, 5 + 34 + 4, d, c0);
    for (int i = 0; i < 100; i++) begin
      if (slots_left == 10'd2) break;
      tick();
    end
    check("freeze_slot2_cyc", cyc, c0 + 44);
    repeat (4) tick();
    ch_idle = 1'b0;
    repeat (5) tick();
    check("freeze_slots", slots_left, 2);
    check("freeze_state", state, ST_IFS);
    ch_idle = 1'b1;
    wait_grant(200);
    finish_tx();

    // Abort during BACKOFF.
    wait_draw3();
    send_req(1'b0, 0, d, c0);
    wait_state(ST_BACKOFF, "reach_backoff");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_bo_state", state, ST_IDLE);
    check("abort_bo_slots", slots_left, 0);
    check("abort_bo_busy", busy, 0);
    repeat (60) tick();
    check("abort_bo_idle", state, ST_IDLE);

    // Abort on the very cycle the IFS expires into GRANT.
    cw_exp = 4'd0; ifs_time = 12'd3;
    send_req(1'b0, 0, d, c0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_exp_state", state, ST_IDLE);
    check("abort_exp_grant", tx_grant, 0);
    repeat (10) tick();

    // abort and tx_done together in WAIT_DONE.
    ifs_time = 12'd34;
    send_req(1'b1, 0, d, c0);
    wait_grant(100);
    tick();
    check("wd_state", state, ST_WAIT_DONE);
    abort = 1'b1; tx_done = 1'b1;
    tick();
    abort = 1'b0; tx_done = 1'b0;
    check("abort_done_state", state, ST_IDLE);
    check("abort_done_slots", slots_left, 0);
    check("abort_done_busy", busy, 0);

    // Reset asserted in BACKOFF discards the attempt.
    cw_exp = 4'd2;
    wait_draw3();
    send_req(1'b0, 0, d, c0);
    wait_state(ST_BACKOFF, "reach_backoff_rst");
    rstn = 1'b0;
    #1;
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", tx_grant, 0);
    check("mid_rst_slots", slots_left, 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (50) tick();
    check("post_rst_state", state, ST_IDLE);
    cw_exp = 4'd5;
    send_req(1'b1, 0, d, c0);
    wait_grant(400);
    finish_tx();

    // ifs_time=0 and slot_time=0 each mean one idle cycle.
    ifs_time = 12'd0; slot_time = 12'd0; cw_exp = 4'd3;
    for (int k = 0; k < 4; k++) begin
      send_req(1'b1, 0, d, c0);
      wait_grant(40);
      finish_tx();
      repeat (k + 1) tick();
    end

    // cw_exp above the clamp: 1000 draws, each aborted in IFS.
    ifs_time = 12'd34; slot_time = 12'd9; cw_exp = 4'd15;
    draw_err = 0;
    max_draw = 0;
    for (int k = 0; k < 1000; k++) begin
      d = m_lfsr[9:0];
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      if (slots_left !== d) draw_err++;
      if (int'(slots_left) > int'(max_draw)) max_draw = slots_left;
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    check("cw15_draw_errors", draw_err, 0);
    check("cw15_max_le_1023", (max_draw <= 1023) ? 1 : 0, 1);
    check("cw15_final_state", state, ST_IDLE);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
